// File: rtl/pc_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_reg_if
// Brief    : Next-PC in / registered PC and status out, between fetch and PC reg.
// Revision : 1.0
// ============================================================================
interface pc_reg_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] old_pc;
  logic [XLEN-1:0] new_pc;
  logic            pc_valid;
  logic            pc_misaligned;

  // master = upstream next-PC logic, slave = the PC register itself
  modport master (
    output old_pc,
    input  new_pc,
    input  pc_valid,
    input  pc_misaligned
  );

  modport slave (
    input  old_pc,
    output new_pc,
    output pc_valid,
    output pc_misaligned
  );
endinterface : pc_reg_if
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : pc_reg
// Brief    : Program-counter register with registered valid and misalign flags.
// Revision : 1.0
// ============================================================================
module pc_reg #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  wire        clk,
  input  wire        reset,
  pc_reg_if.slave    pc_if
);

  localparam logic c_rv_misaligned = (RESET_VECTOR[1:0] != 2'b00);

  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_misaligned;

  // Low PC bits are kept as-is; misalignment is only flagged for the trap logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_VECTOR;
      r_valid      <= 1'b0;
      r_misaligned <= c_rv_misaligned;
    end else begin
      r_pc         <= pc_if.old_pc;
      r_valid      <= 1'b1;
      r_misaligned <= (pc_if.old_pc[1:0] != 2'b00);
    end
  end

  assign pc_if.new_pc        = r_pc;
  assign pc_if.pc_valid      = r_valid;
  assign pc_if.pc_misaligned = r_misaligned;

endmodule : pc_reg
`default_nettype wire

// File: tb/tb_pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_reg
// Brief    : Directed self-checking bench for pc_reg (three reset-vector variants).
// Revision : 1.0
// ============================================================================
module tb_pc_reg;

  logic        clk;
  logic        clk_en;
  logic        reset;
  logic [31:0] drv_pc;

  int n_cmp;
  int n_err;

  pc_reg_if #(.XLEN(32)) bus_def ();
  pc_reg_if #(.XLEN(32)) bus_hi  ();
  pc_reg_if #(.XLEN(32)) bus_mis ();

  assign bus_def.old_pc = drv_pc;
  assign bus_hi.old_pc  = drv_pc;
  assign bus_mis.old_pc = drv_pc;

  pc_reg #(.XLEN(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .pc_if (bus_def.slave)
  );

  pc_reg #(.XLEN(32), .RESET_VECTOR(32'h8000_0000)) u_dut_hi (
    .clk   (clk),
    .reset (reset),
    .pc_if (bus_hi.slave)
  );

  pc_reg #(.XLEN(32), .RESET_VECTOR(32'h0000_0002)) u_dut_mis (
    .clk   (clk),
    .reset (reset),
    .pc_if (bus_mis.slave)
  );

  // Clock is gated so the reset-only phase can run with clk held still.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    clk    = 1'b0;
    clk_en = 1'b0;
    reset  = 1'b1;
    drv_pc = 32'h0;

    // 1. reset only, clock idle
    #1;
    chk("rst_pc",        bus_def.new_pc,               32'h0000_0000);
    chk("rst_valid",     {31'b0, bus_def.pc_valid},    32'd0);
    chk("rst_mis",       {31'b0, bus_def.pc_misaligned}, 32'd0);
    chk("rst_hi_pc",     bus_hi.new_pc,                32'h8000_0000);
    chk("rst_mis_pc",    bus_mis.new_pc,               32'h0000_0002);
    chk("rst_mis_flag",  {31'b0, bus_mis.pc_misaligned}, 32'd1);
    reset = 1'b0;
    #10;
    chk("idle_pc_a",     bus_def.new_pc,               32'h0000_0000);
    chk("idle_valid_a",  {31'b0, bus_def.pc_valid},    32'd0);
    #10;
    chk("idle_pc_b",     bus_def.new_pc,               32'h0000_0000);
    chk("idle_valid_b",  {31'b0, bus_def.pc_valid},    32'd0);
    chk("idle_mis_b",    {31'b0, bus_def.pc_misaligned}, 32'd0);

    // 2. sequential fetch
    clk_en = 1'b1;
    drv_pc = 32'h0;
    tick();
    chk("seq0_pc",       bus_def.new_pc,               32'h0000_0000);
    chk("seq0_valid",    {31'b0, bus_def.pc_valid},    32'd1);
    chk("seq0_mis",      {31'b0, bus_def.pc_misaligned}, 32'd0);
    drv_pc = 32'h4;
    #1;
    chk("no_comb_path",  bus_def.new_pc,               32'h0000_0000);
    tick();
    chk("seq4_pc",       bus_def.new_pc,               32'h0000_0004);
    drv_pc = 32'h8;
    tick();
    chk("seq8_pc",       bus_def.new_pc,               32'h0000_0008);
    drv_pc = 32'hC;
    tick();
    chk("seqC_pc",       bus_def.new_pc,               32'h0000_000C);
    chk("seqC_mis",      {31'b0, bus_def.pc_misaligned}, 32'd0);

    // 3. branch targets
    drv_pc = 32'h100;
    tick();
    chk("br100_pc",      bus_def.new_pc,               32'h0000_0100);
    drv_pc = 32'h40;
    tick();
    chk("br40_pc",       bus_def.new_pc,               32'h0000_0040);

    // 4. misalignment
    drv_pc = 32'h102;
    tick();
    chk("mis102_pc",     bus_def.new_pc,               32'h0000_0102);
    chk("mis102_flag",   {31'b0, bus_def.pc_misaligned}, 32'd1);
    drv_pc = 32'h104;
    tick();
    chk("al104_pc",      bus_def.new_pc,               32'h0000_0104);
    chk("al104_flag",    {31'b0, bus_def.pc_misaligned}, 32'd0);
    chk("al104_mi_flag", {31'b0, bus_mis.pc_misaligned}, 32'd0);

    // 5. async reset between edges
    drv_pc = 32'h200;
    tick();
    chk("pre_rst_pc",    bus_def.new_pc,               32'h0000_0200);
    #2;
    reset  = 1'b1;
    drv_pc = 32'h300;
    #1;
    chk("arst_pc",       bus_def.new_pc,               32'h0000_0000);
    chk("arst_valid",    {31'b0, bus_def.pc_valid},    32'd0);
    chk("arst_hi_pc",    bus_hi.new_pc,                32'h8000_0000);
    tick();
    tick();
    chk("hold_rst_pc",   bus_def.new_pc,               32'h0000_0000);
    chk("hold_rst_vld",  {31'b0, bus_def.pc_valid},    32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("rel_pc",        bus_def.new_pc,               32'h0000_0000);
    chk("rel_valid",     {31'b0, bus_def.pc_valid},    32'd0);
    tick();
    chk("post_rel_pc",   bus_def.new_pc,               32'h0000_0300);
    chk("post_rel_vld",  {31'b0, bus_def.pc_valid},    32'd1);

    // 6. top-of-range value and non-zero reset vector
    drv_pc = 32'hFFFF_FFFC;
    tick();
    chk("top_pc",        bus_def.new_pc,               32'hFFFF_FFFC);
    chk("top_hi_pc",     bus_hi.new_pc,                32'hFFFF_FFFC);
    #2;
    reset = 1'b1;
    #1;
    chk("hi_rst_pc",     bus_hi.new_pc,                32'h8000_0000);
    chk("hi_rst_valid",  {31'b0, bus_hi.pc_valid},     32'd0);
    chk("def_rst_pc",    bus_def.new_pc,               32'h0000_0000);
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pc_reg
`default_nettype wire
